// File: rtl/cell_fwd_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : cell_fwd_sched_if
// Brief    : Rx-buffer / Tx-FIFO handshake bundle of the cell forwarding
//            scheduler.
// Revision : 1.0
// ============================================================================
interface cell_fwd_sched_if #(
    parameter int NUM_RX = 4,
    parameter int NUM_TX = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_RX-1:0]        rx_req;
    logic [NUM_RX*NUM_TX-1:0] rx_fwd;
    logic [NUM_RX-1:0]        rx_ack;
    logic [NUM_RX-1:0]        rx_rd;
    logic [NUM_TX-1:0]        tx_ready;
    logic [NUM_TX-1:0]        tx_wr;
    logic [SEL_W-1:0]         sel;
    logic [5:0]               byte_idx;
    logic                     busy;
    logic [15:0]              drop_cnt;

    // master: the scheduler; slave: the Rx buffers / Tx FIFOs around it
    modport master (
        input  rx_req, rx_fwd, tx_ready,
        output rx_ack, rx_rd, tx_wr, sel, byte_idx, busy, drop_cnt
    );
    modport slave (
        output rx_req, rx_fwd, tx_ready,
        input  rx_ack, rx_rd, tx_wr, sel, byte_idx, busy, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cell_fwd_sched.sv
`default_nettype none
// ============================================================================
// Module   : cell_fwd_sched
// Brief    : Round-robin Rx-to-Tx cell forwarding scheduler (53-beat transfers).
//            SQUAT_FWDALL_EN: broadcast every cell to all Tx ports.
// Revision : 1.0
// ============================================================================
module cell_fwd_sched #(
    parameter int NUM_RX     = 4,
    parameter int NUM_TX     = 4,
    parameter int CELL_BYTES = 53
) (
    input  wire logic         clk,
    input  wire logic         rst,
    cell_fwd_sched_if.master  bus
);
    localparam int GW = (NUM_RX > 1) ? $clog2(NUM_RX) : 1;
    localparam logic [5:0] c_last_beat = 6'(CELL_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_TX = 3'd1,
        S_XFER    = 3'd2,
        S_DONE    = 3'd3,
        S_DROP    = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [GW-1:0]       r_ptr, r_grant, w_grant_nxt, w_pick, w_cand, w_ptr_inc;
    logic [NUM_TX-1:0]   r_mask, w_mask_nxt, w_fwd;
    logic [NUM_RX-1:0]   w_grant_oh;
    logic                w_found;
    logic [5:0]          r_byte_idx;
    logic [NUM_RX-1:0]   r_rx_ack, r_rx_rd;
    logic [NUM_TX-1:0]   r_tx_wr;
    logic [15:0]         r_drop_cnt;

    // First requester at or after the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_cand  = r_ptr;
        for (int k = 0; k < NUM_RX; k++) begin
            w_cand = (int'(r_ptr) + k >= NUM_RX) ? GW'(int'(r_ptr) + k - NUM_RX)
                                                 : GW'(int'(r_ptr) + k);
            if (!w_found && bus.rx_req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin
        w_fwd = '0;
        for (int i = 0; i < NUM_RX; i++) begin
            if (w_pick == GW'(i)) w_fwd = bus.rx_fwd[i*NUM_TX +: NUM_TX];
        end
    end

    always_comb begin
        w_grant_oh = '0;
        for (int i = 0; i < NUM_RX; i++) begin
            w_grant_oh[i] = (r_grant == GW'(i));
        end
    end

    assign w_ptr_inc = (r_grant == GW'(NUM_RX - 1)) ? '0 : r_grant + GW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_mask_nxt  = r_mask;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_pick;
`ifdef SQUAT_FWDALL_EN
                    w_mask_nxt  = '1;
`else
                    w_mask_nxt  = w_fwd;
`endif
                    w_state_nxt = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (r_mask == '0)
                    w_state_nxt = S_DROP;
                else if ((bus.tx_ready & r_mask) == r_mask)
                    w_state_nxt = S_XFER;
            end
            S_XFER: begin
                if (r_byte_idx == c_last_beat) w_state_nxt = S_DONE;
            end
            S_DONE, S_DROP: w_state_nxt = S_IDLE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_mask     <= '0;
            r_byte_idx <= '0;
            r_rx_ack   <= '0;
            r_rx_rd    <= '0;
            r_tx_wr    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_mask  <= w_mask_nxt;
            if (w_state_nxt == S_DONE || w_state_nxt == S_DROP) r_ptr <= w_ptr_inc;
            // Strobes are registered off the next state so they line up with it
            r_byte_idx <= (w_state_nxt == S_XFER && r_state == S_XFER) ? r_byte_idx + 6'd1 : 6'd0;
            r_rx_rd    <= (w_state_nxt == S_XFER) ? w_grant_oh : '0;
            r_tx_wr    <= (w_state_nxt == S_XFER) ? r_mask : '0;
            r_rx_ack   <= (w_state_nxt == S_DONE || w_state_nxt == S_DROP) ? w_grant_oh : '0;
            if (w_state_nxt == S_DROP && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign bus.rx_ack   = r_rx_ack;
    assign bus.rx_rd    = r_rx_rd;
    assign bus.tx_wr    = r_tx_wr;
    assign bus.sel      = r_grant;
    assign bus.byte_idx = r_byte_idx;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.drop_cnt = r_drop_cnt;
endmodule
`default_nettype wire

// File: tb/tb_cell_fwd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cell_fwd_sched
// Brief    : Directed self-checking bench for cell_fwd_sched.
// Revision : 1.0
// ============================================================================
module tb_cell_fwd_sched;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    cell_fwd_sched_if #(.NUM_RX(4), .NUM_TX(4), .SEL_W(2)) bus ();

    cell_fwd_sched #(.NUM_RX(4), .NUM_TX(4), .CELL_BYTES(53)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Entered in a WAIT_TX cycle whose targets are ready; covers beats, ack and return to IDLE
    task automatic xfer_check(input int g, input logic [3:0] m, input int disturb_at, input bit clr);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        tick();
        for (int i = 0; i < 53; i++) begin
            check("beat_tx_wr",    32'(bus.tx_wr),    32'(m));
            check("beat_rx_rd",    32'(bus.rx_rd),    32'(oh));
            check("beat_byte_idx", 32'(bus.byte_idx), i);
            check("beat_sel",      32'(bus.sel),      g);
            check("beat_no_ack",   32'(bus.rx_ack),   0);
            if (i == disturb_at) begin
                bus.tx_ready = 4'h0;
                bus.rx_req   = 4'h0;
            end
            tick();
        end
        check("done_ack",      32'(bus.rx_ack),   32'(oh));
        check("done_tx_wr",    32'(bus.tx_wr),    0);
        check("done_rx_rd",    32'(bus.rx_rd),    0);
        check("done_byte_idx", 32'(bus.byte_idx), 0);
        check("done_busy",     32'(bus.busy),     1);
        if (clr) bus.rx_req[g] = 1'b0;
        tick();
        check("idle_busy", 32'(bus.busy),   0);
        check("idle_ack",  32'(bus.rx_ack), 0);
    endtask

    initial begin
        n_total      = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus.rx_req   = '0;
        bus.rx_fwd   = '0;
        bus.tx_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack",      32'(bus.rx_ack),   0);
        check("rst_rd",       32'(bus.rx_rd),    0);
        check("rst_wr",       32'(bus.tx_wr),    0);
        check("rst_sel",      32'(bus.sel),      0);
        check("rst_byte_idx", 32'(bus.byte_idx), 0);
        check("rst_busy",     32'(bus.busy),     0);
        check("rst_drop_cnt", 32'(bus.drop_cnt), 0);
        rst = 1'b0;

        // Single port 0 -> Tx port 2
        bus.rx_req   = 4'b0001;
        bus.rx_fwd   = 16'h0004;
        bus.tx_ready = 4'hF;
        tick();
        check("single_wait_busy", 32'(bus.busy),  1);
        check("single_wait_wr",   32'(bus.tx_wr), 0);
        xfer_check(0, 4'b0100, -1, 1'b1);

        // Round robin from a fresh pointer: 0,1,2,3,0
        rst = 1'b1;
        #1;
        rst = 1'b0;
        bus.rx_req = 4'hF;
        bus.rx_fwd = 16'h8421;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_wait_sel", 32'(bus.sel), k % 4);
            xfer_check(k % 4, 4'(4'b0001 << (k % 4)), -1, 1'b0);
        end
        bus.rx_req = 4'h0;
        tick();
        check("rr_idle_busy", 32'(bus.busy), 0);

        // Backpressure on port 1 (pointer now 1)
        bus.rx_req   = 4'b0010;
        bus.rx_fwd   = 16'h00A0;
        bus.tx_ready = 4'b0010;
        tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            check("bp_no_wr", 32'(bus.tx_wr), 0);
            check("bp_busy",  32'(bus.busy),  1);
        end
        bus.tx_ready = 4'b1010;
        xfer_check(1, 4'b1010, -1, 1'b1);

        // Empty mask on port 2 is dropped
        bus.rx_req   = 4'b0100;
        bus.rx_fwd   = 16'h0000;
        bus.tx_ready = 4'hF;
        tick();
        check("drop_wait_ack", 32'(bus.rx_ack), 0);
        tick();
        check("drop_ack",      32'(bus.rx_ack),   32'h4);
        check("drop_no_wr",    32'(bus.tx_wr),    0);
        check("drop_cnt",      32'(bus.drop_cnt), 1);
        bus.rx_req = 4'h0;
        tick();
        check("drop_idle_busy", 32'(bus.busy),     0);
        check("drop_idle_ack",  32'(bus.rx_ack),   0);
        check("drop_cnt_hold",  32'(bus.drop_cnt), 1);

        // Reset in the middle of a port-3 transfer
        bus.rx_req = 4'b1000;
        bus.rx_fwd = 16'hF0FF;
        tick();
        check("mid_rst_sel3", 32'(bus.sel), 3);
        repeat (21) tick();
        check("mid_rst_idx20", 32'(bus.byte_idx), 20);
        rst = 1'b1;
        #1;
        check("arst_wr",       32'(bus.tx_wr),    0);
        check("arst_rd",       32'(bus.rx_rd),    0);
        check("arst_sel",      32'(bus.sel),      0);
        check("arst_byte_idx", 32'(bus.byte_idx), 0);
        check("arst_busy",     32'(bus.busy),     0);
        check("arst_drop_cnt", 32'(bus.drop_cnt), 0);
        rst = 1'b0;
        bus.rx_req = 4'b1011;
        tick();
        check("post_rst_sel0", 32'(bus.sel), 0);
        bus.rx_req = 4'b0001;
        xfer_check(0, 4'hF, -1, 1'b1);

        // tx_ready and rx_req drop at byte 10 of a port-1 transfer
        bus.rx_req   = 4'b0010;
        bus.rx_fwd   = 16'h0060;
        bus.tx_ready = 4'hF;
        tick();
        xfer_check(1, 4'b0110, 10, 1'b1);
        repeat (3) begin
            tick();
            check("dist_single_ack", 32'(bus.rx_ack), 0);
            check("dist_idle",       32'(bus.busy),   0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
